// File: rtl/doorlock_param.sv
// rtl/doorlock_param.sv - keypad door lock: password check, timed release, lockout, password change
// Digits accumulate in an entry buffer; '#'/'*' decide; all outputs come straight from flops.
module doorlock_param #(
  parameter int MAX_LEN     = 8,
  parameter int MIN_LEN     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int UNLOCK_CYC  = 500,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       key_v,
  input  logic [3:0] key,
  input  logic       sw_reset,
  output logic       lockOP,
  output logic       storeLED,
  output logic       alarm,
  output logic       err,
  output logic       pw_chg,
  output logic [3:0] fail_cnt
);
  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [MAX_LEN*4-1:0] RESET_PW = (MAX_LEN*4)'(16'h4321);

  typedef enum logic [2:0] {ST_IDLE, ST_OPEN, ST_NEW, ST_CONF, ST_LOCK} state_t;

  state_t                  state_q, state_d;
  logic [MAX_LEN-1:0][3:0] pw_q, pw_d, buf_q, buf_d, cand_q, cand_d;
  logic [LW-1:0]           pw_len_q, pw_len_d, buf_len_q, buf_len_d, cand_len_q, cand_len_d;
  logic                    ovf_q, ovf_d;
  logic [3:0]              fail_q, fail_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    lock_op_q, lock_op_d, store_led_q, store_led_d;
  logic                    alarm_q, alarm_d, err_q, err_d, pw_chg_q, pw_chg_d;

  logic       is_digit, is_star, is_hash;
  logic       pw_match, cand_match, clear_buf;
  logic [4:0] fail_inc;

  assign is_digit = key_v && (key <= 4'd9);
  assign is_star  = key_v && (key == 4'd10);
  assign is_hash  = key_v && (key == 4'd11);
  assign fail_inc = {1'b0, fail_q} + 5'd1;

  // Only positions below the reference length take part in the comparison.
  always_comb begin
    pw_match   = !ovf_q && (buf_len_q == pw_len_q);
    cand_match = !ovf_q && (buf_len_q == cand_len_q);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < pw_len_q) && (buf_q[i] != pw_q[i])) pw_match = 1'b0;
      if ((LW'(i) < cand_len_q) && (buf_q[i] != cand_q[i])) cand_match = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    pw_len_d   = pw_len_q;
    buf_d      = buf_q;
    buf_len_d  = buf_len_q;
    ovf_d      = ovf_q;
    cand_d     = cand_q;
    cand_len_d = cand_len_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    err_d      = 1'b0;
    pw_chg_d   = 1'b0;
    clear_buf  = 1'b0;

    if (sw_reset && (state_q != ST_LOCK)) begin
      state_d   = ST_NEW;
      timer_d   = '0;
      clear_buf = 1'b1;
    end else begin
      if (is_digit && (state_q == ST_IDLE || state_q == ST_NEW || state_q == ST_CONF)) begin
        if (buf_len_q == LW'(MAX_LEN)) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (buf_len_q == LW'(i)) buf_d[i] = key;
          end
          buf_len_d = buf_len_q + LW'(1);
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (is_hash || is_star) begin
            clear_buf = 1'b1;
            if (pw_match) begin
              fail_d = '0;
              if (is_hash) begin
                state_d = ST_OPEN;
                timer_d = TW'(UNLOCK_CYC - 1);
              end else begin
                state_d = ST_NEW;
              end
            end else begin
              err_d = 1'b1;
              if (fail_inc >= 5'(MAX_FAIL)) begin
                fail_d  = 4'(MAX_FAIL);
                state_d = ST_LOCK;
                timer_d = TW'(LOCKOUT_CYC - 1);
              end else begin
                fail_d = fail_inc[3:0];
              end
            end
          end
        end
        ST_OPEN, ST_LOCK: begin
          if (timer_q == '0) begin
            state_d = ST_IDLE;
            if (state_q == ST_LOCK) fail_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_NEW: begin
          if (is_hash && !ovf_q && (buf_len_q >= LW'(MIN_LEN))) begin
            cand_d     = buf_q;
            cand_len_d = buf_len_q;
            state_d    = ST_CONF;
          end else if (is_hash || is_star) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_CONF: begin
          if (is_hash && cand_match) begin
            pw_d     = cand_q;
            pw_len_d = cand_len_q;
            pw_chg_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (is_hash || is_star) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clear_buf || (state_d != state_q)) begin
      buf_d     = '0;
      buf_len_d = '0;
      ovf_d     = 1'b0;
    end

    lock_op_d   = (state_d == ST_OPEN);
    store_led_d = (state_d == ST_NEW) || (state_d == ST_CONF);
    alarm_d     = (state_d == ST_LOCK);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pw_q        <= RESET_PW;
      pw_len_q    <= LW'(4);
      buf_q       <= '0;
      buf_len_q   <= '0;
      ovf_q       <= 1'b0;
      cand_q      <= '0;
      cand_len_q  <= '0;
      fail_q      <= '0;
      timer_q     <= '0;
      lock_op_q   <= 1'b0;
      store_led_q <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      pw_chg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      pw_len_q    <= pw_len_d;
      buf_q       <= buf_d;
      buf_len_q   <= buf_len_d;
      ovf_q       <= ovf_d;
      cand_q      <= cand_d;
      cand_len_q  <= cand_len_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      lock_op_q   <= lock_op_d;
      store_led_q <= store_led_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      pw_chg_q    <= pw_chg_d;
    end
  end

  assign lockOP   = lock_op_q;
  assign storeLED = store_led_q;
  assign alarm    = alarm_q;
  assign err      = err_q;
  assign pw_chg   = pw_chg_q;
  assign fail_cnt = fail_q;
endmodule

// File: tb/tb_doorlock_param.sv
// tb/tb_doorlock_param.sv - directed scenarios plus randomized key traffic against a queue-based lock model
module tb_doorlock_param;
  localparam int MAX_LEN     = 8;
  localparam int MIN_LEN     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int UNLOCK_CYC  = 500;
  localparam int LOCKOUT_CYC = 1000;
  localparam int M_IDLE = 0, M_OPEN = 1, M_NEW = 2, M_CONF = 3, M_LOCK = 4;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       key_v = 1'b0;
  logic [3:0] key = 4'd0;
  logic       sw_reset = 1'b0;
  logic       lockOP, storeLED, alarm, err, pw_chg;
  logic [3:0] fail_cnt;
  logic [8:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_err, cnt_chg, cnt_lock, cnt_alarm;

  doorlock_param #(
    .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .MAX_FAIL(MAX_FAIL),
    .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .CLK(CLK), .rst(rst), .key_v(key_v), .key(key), .sw_reset(sw_reset),
    .lockOP(lockOP), .storeLED(storeLED), .alarm(alarm), .err(err),
    .pw_chg(pw_chg), .fail_cnt(fail_cnt)
  );

  always #5 CLK = ~CLK;
  assign obs = {lockOP, storeLED, alarm, err, pw_chg, fail_cnt};

  // Behavioural model: password/entry/candidate as digit queues, a mode, a countdown.
  int m_mode, m_fail, m_remain;
  bit m_ovf, m_err, m_chg;
  int m_pw[$], m_entry[$], m_cand[$];

  typedef struct {bit kv; logic [3:0] k; bit swr;} stim_t;
  stim_t sq[$];

  function automatic bit same_seq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_pw = '{1, 2, 3, 4}; m_entry.delete(); m_cand.delete();
    m_ovf = 0; m_fail = 0; m_remain = 0; m_err = 0; m_chg = 0;
  endfunction

  function automatic void go(input int nm);
    m_mode = nm; m_entry.delete(); m_ovf = 0;
  endfunction

  function automatic void model_step(input bit kv, input int k, input bit swr);
    bit hash, star;
    hash = kv && (k == 11);
    star = kv && (k == 10);
    m_err = 0; m_chg = 0;
    if (swr && m_mode != M_LOCK) begin go(M_NEW); return; end
    if (m_mode == M_OPEN || m_mode == M_LOCK) begin
      m_remain = m_remain - 1;
      if (m_remain == 0) begin
        if (m_mode == M_LOCK) m_fail = 0;
        go(M_IDLE);
      end
      return;
    end
    if (kv && k < 10) begin
      if (m_entry.size() == MAX_LEN) m_ovf = 1; else m_entry.push_back(k);
    end
    if (!(hash || star)) return;
    case (m_mode)
      M_IDLE: begin
        if (!m_ovf && same_seq(m_entry, m_pw)) begin
          m_fail = 0;
          if (hash) begin m_remain = UNLOCK_CYC; go(M_OPEN); end else go(M_NEW);
        end else begin
          m_err = 1;
          m_fail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
          if (m_fail == MAX_FAIL) begin m_remain = LOCKOUT_CYC; go(M_LOCK); end else go(M_IDLE);
        end
      end
      M_NEW: begin
        if (hash && !m_ovf && m_entry.size() >= MIN_LEN) begin m_cand = m_entry; go(M_CONF); end
        else begin m_err = 1; go(M_IDLE); end
      end
      default: begin
        if (hash && !m_ovf && same_seq(m_entry, m_cand)) begin m_pw = m_cand; m_chg = 1; end
        else m_err = 1;
        go(M_IDLE);
      end
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    logic o, s, a;
    o = (m_mode == M_OPEN);
    s = (m_mode == M_NEW) || (m_mode == M_CONF);
    a = (m_mode == M_LOCK);
    return {o, s, a, logic'(m_err), logic'(m_chg), 4'(m_fail)};
  endfunction

  task automatic cycle(input bit kv, input logic [3:0] k, input bit swr);
    @(negedge CLK);
    key_v = kv; key = k; sw_reset = swr;
    @(posedge CLK);
    model_step(kv, int'(k), swr);
    #1;
    if (err === 1'b1) cnt_err++;
    if (pw_chg === 1'b1) cnt_chg++;
    if (lockOP === 1'b1) cnt_lock++;
    if (alarm === 1'b1) cnt_alarm++;
  endtask

  task automatic press(input int k);
    cycle(1'b1, 4'(k), 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    rst = 1'b1; key_v = 1'b0; sw_reset = 1'b0; key = 4'd0;
    @(negedge CLK);
    rst = 1'b0;
    model_reset();
    cnt_err = 0; cnt_chg = 0; cnt_lock = 0; cnt_alarm = 0;
  endtask

  function automatic void push(input bit kv, input int k, input bit swr);
    stim_t s;
    s.kv = kv; s.k = 4'(k); s.swr = swr;
    sq.push_back(s);
    repeat ($urandom_range(0, 2)) begin
      s.kv = 1'b0; s.k = 4'($urandom_range(0, 15)); s.swr = 1'b0;
      sq.push_back(s);
    end
  endfunction

  function automatic void push_new_pw();
    int nd[$];
    int len;
    len = $urandom_range(1, MAX_LEN + 1);
    repeat (len) nd.push_back($urandom_range(0, 9));
    foreach (nd[i]) push(1, nd[i], 0);
    push(1, ($urandom_range(0, 5) == 0) ? 10 : 11, 0);
    if ($urandom_range(0, 3) == 0) nd[0] = (nd[0] + 1) % 10;
    foreach (nd[i]) push(1, nd[i], 0);
    push(1, ($urandom_range(0, 7) == 0) ? 10 : 11, 0);
  endfunction

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs !== 9'b0) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0); end
    cycle(1'b0, 4'd0, 1'b1);
    press(1);
    n_checks++;
    if (storeLED !== 1'b1) begin n_fail++; $display("FAIL reset_pre_store got=%b want=1", storeLED); end
    @(negedge CLK);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 9'b0) begin n_fail++; $display("FAIL reset_async got=%b want=%b", obs, 9'b0); end
    @(negedge CLK);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_unlock();
    apply_reset();
    press(1); press(2); press(3); press(4);
    n_checks++;
    if (lockOP !== 1'b0) begin n_fail++; $display("FAIL unlock_early got=%b want=0", lockOP); end
    press(11);
    n_checks++;
    if (lockOP !== 1'b1) begin n_fail++; $display("FAIL unlock_rise got=%b want=1", lockOP); end
    for (int i = 0; i < 700 && lockOP === 1'b1; i++) cycle(1'b0, 4'd0, 1'b0);
    n_checks++;
    if (cnt_lock != UNLOCK_CYC) begin n_fail++; $display("FAIL unlock_len got=%0d want=%0d", cnt_lock, UNLOCK_CYC); end
    n_checks++;
    if (obs !== exp_vec() || fail_cnt !== 4'd0) begin n_fail++; $display("FAIL unlock_end got=%b want=%b", obs, exp_vec()); end
  endtask

  task automatic test_lockout();
    int seq1[$], seq2[$], seq3[$];
    apply_reset();
    seq1 = '{1, 2, 3, 11}; seq2 = '{9, 9, 9, 9, 11}; seq3 = '{1, 2, 3, 4, 5, 11};
    foreach (seq1[i]) press(seq1[i]);
    n_checks++;
    if (fail_cnt !== 4'd1 || err !== 1'b1) begin n_fail++; $display("FAIL lock_first got=%0d/%b want=1/1", fail_cnt, err); end
    foreach (seq2[i]) press(seq2[i]);
    n_checks++;
    if (fail_cnt !== 4'd2 || alarm !== 1'b0) begin n_fail++; $display("FAIL lock_second got=%0d/%b want=2/0", fail_cnt, alarm); end
    foreach (seq3[i]) press(seq3[i]);
    n_checks++;
    if (alarm !== 1'b1 || fail_cnt !== 4'(MAX_FAIL)) begin n_fail++; $display("FAIL lock_enter got=%b/%0d want=1/%0d", alarm, fail_cnt, MAX_FAIL); end
    repeat (100) cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    n_checks++;
    if (obs !== exp_vec() || alarm !== 1'b1) begin n_fail++; $display("FAIL lock_ignore got=%b want=%b", obs, exp_vec()); end
    for (int i = 0; i < 1500 && alarm === 1'b1; i++) cycle(1'b0, 4'd0, 1'b0);
    n_checks++;
    if (cnt_alarm != LOCKOUT_CYC) begin n_fail++; $display("FAIL lock_len got=%0d want=%0d", cnt_alarm, LOCKOUT_CYC); end
    n_checks++;
    if (cnt_err != 3) begin n_fail++; $display("FAIL lock_errs got=%0d want=3", cnt_err); end
    n_checks++;
    if (fail_cnt !== 4'd0 || obs !== 9'b0) begin n_fail++; $display("FAIL lock_exit got=%b want=%b", obs, 9'b0); end
  endtask

  task automatic test_change_pw();
    int np[$];
    np = '{5, 6, 7, 8, 9};
    press(1); press(2); press(3); press(4); press(10);
    n_checks++;
    if (storeLED !== 1'b1) begin n_fail++; $display("FAIL chg_new got=%b want=1", storeLED); end
    foreach (np[i]) press(np[i]);
    press(11);
    n_checks++;
    if (storeLED !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL chg_conf got=%b/%b want=1/0", storeLED, err); end
    foreach (np[i]) press(np[i]);
    press(11);
    n_checks++;
    if (pw_chg !== 1'b1 || storeLED !== 1'b0) begin n_fail++; $display("FAIL chg_commit got=%b/%b want=1/0", pw_chg, storeLED); end
    foreach (np[i]) press(np[i]);
    press(11);
    n_checks++;
    if (lockOP !== 1'b1) begin n_fail++; $display("FAIL chg_newpw_open got=%b want=1", lockOP); end
    for (int i = 0; i < 700 && lockOP === 1'b1; i++) cycle(1'b0, 4'd0, 1'b0);
    press(1); press(2); press(3); press(4); press(11);
    n_checks++;
    if (err !== 1'b1 || lockOP !== 1'b0 || fail_cnt !== 4'd1) begin n_fail++; $display("FAIL chg_oldpw got=%b want=%b", obs, 9'b000100001); end
  endtask

  task automatic test_store_abort();
    int np[$];
    np = '{6, 7, 8, 9};
    cycle(1'b0, 4'd0, 1'b1);
    n_checks++;
    if (storeLED !== 1'b1) begin n_fail++; $display("FAIL abort_enter got=%b want=1", storeLED); end
    press(7); press(7); press(11);
    n_checks++;
    if (err !== 1'b1 || storeLED !== 1'b0) begin n_fail++; $display("FAIL abort_short got=%b/%b want=1/0", err, storeLED); end
    press(5); press(6); press(7); press(8); press(9); press(11);
    n_checks++;
    if (lockOP !== 1'b1) begin n_fail++; $display("FAIL abort_pw_kept got=%b want=1", lockOP); end
    for (int i = 0; i < 700 && lockOP === 1'b1; i++) cycle(1'b0, 4'd0, 1'b0);
    cycle(1'b1, 4'd5, 1'b1);
    n_checks++;
    if (storeLED !== 1'b1) begin n_fail++; $display("FAIL abort_swr_key got=%b want=1", storeLED); end
    foreach (np[i]) press(np[i]);
    press(11);
    foreach (np[i]) press(np[i]);
    press(11);
    n_checks++;
    if (pw_chg !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL abort_key_dropped got=%b/%b want=1/0", pw_chg, err); end
    foreach (np[i]) press(np[i]);
    press(11);
    n_checks++;
    if (lockOP !== 1'b1) begin n_fail++; $display("FAIL abort_4digit_open got=%b want=1", lockOP); end
    for (int i = 0; i < 700 && lockOP === 1'b1; i++) cycle(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int d = 1; d <= 9; d++) press(d);
    press(11);
    n_checks++;
    if (err !== 1'b1 || fail_cnt !== 4'd1) begin n_fail++; $display("FAIL ovf_idle got=%b/%0d want=1/1", err, fail_cnt); end
    cycle(1'b0, 4'd0, 1'b1);
    for (int d = 1; d <= 9; d++) press(d);
    press(11);
    n_checks++;
    if (err !== 1'b1 || storeLED !== 1'b0) begin n_fail++; $display("FAIL ovf_store got=%b/%b want=1/0", err, storeLED); end
    press(1); press(2); press(3); press(4); press(11);
    repeat (10) cycle(1'b0, 4'd0, 1'b0);
    n_checks++;
    if (lockOP !== 1'b1) begin n_fail++; $display("FAIL ovf_open got=%b want=1", lockOP); end
    @(negedge CLK);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (lockOP !== 1'b0 || fail_cnt !== 4'd0) begin n_fail++; $display("FAIL open_async_rst got=%b/%0d want=0/0", lockOP, fail_cnt); end
    @(negedge CLK);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int guard;
    apply_reset();
    for (int a = 0; a < 30; a++) begin
      sq.delete();
      case ($urandom_range(0, 4))
        0: begin foreach (m_pw[i]) push(1, m_pw[i], 0); push(1, 11, 0); end
        1: begin foreach (m_pw[i]) push(1, m_pw[i], 0); push(1, 10, 0); push_new_pw(); end
        2: begin
          repeat ($urandom_range(0, MAX_LEN + 1)) push(1, $urandom_range(0, 9), 0);
          push(1, $urandom_range(10, 11), 0);
        end
        3: begin push($urandom_range(0, 1), $urandom_range(0, 15), 1); push_new_pw(); end
        default: repeat (6) push($urandom_range(0, 1), $urandom_range(12, 15), 0);
      endcase
      foreach (sq[i]) begin
        cycle(sq[i].kv, sq[i].k, sq[i].swr);
        n_checks++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL random a=%0d i=%0d got=%b want=%b", a, i, obs, exp_vec()); end
      end
      guard = 0;
      while ((m_mode == M_OPEN || m_mode == M_LOCK) && guard < 1100) begin
        cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 199) == 0));
        guard++;
        n_checks++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_wait a=%0d c=%0d got=%b want=%b", a, guard, obs, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_change_pw();
    test_store_abort();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/doorlock_param.md
DOORLOCK_PARAM -- requirements
Module: doorlock_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum password length in digits (4..16).
REQ-002 SHALL have parameter MIN_LEN, default 4, minimum accepted new-password length (1..MAX_LEN).
REQ-003 SHALL have parameter MAX_FAIL, default 3, consecutive failed attempts that trigger lockout (1..15).
REQ-004 SHALL have parameter UNLOCK_CYC, default 500, cycles lockOP stays high per successful unlock.
REQ-005 SHALL have parameter LOCKOUT_CYC, default 1000, cycles spent in lockout.
REQ-006 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-008 SHALL have port key_v  in  1  one-cycle strobe, key holds a valid code.
REQ-009 SHALL have port key  in  4  key code: 0-9 digit, 10 '*', 11 '#', 12-15 ignored.
REQ-010 SHALL have port sw_reset  in  1  level request to enter store mode.
REQ-011 SHALL have port lockOP  out  1  door release.
REQ-012 SHALL have port storeLED  out  1  high in ST_NEW or ST_CONF.
REQ-013 SHALL have port alarm  out  1  high in ST_LOCK.
REQ-014 SHALL have port err  out  1  one-cycle pulse on a rejected attempt or aborted store.
REQ-015 SHALL have port pw_chg  out  1  one-cycle pulse when a new password is committed.
REQ-016 SHALL have port fail_cnt  out  4  current consecutive failure count.

Function
REQ-017 SHALL implement states ST_IDLE, ST_OPEN, ST_NEW, ST_CONF, ST_LOCK.
REQ-018 SHALL hold a password store (MAX_LEN x 4 bits plus length) and an entry buffer (MAX_LEN x 4 bits plus length and overflow flag).
REQ-019 SHALL, in ST_IDLE/ST_NEW/ST_CONF, write each digit at buffer index = entry length, increment length; a digit at length MAX_LEN sets overflow and is discarded.
REQ-020 SHALL define "match" as: no overflow, entry length equals stored length, all stored digits equal.
REQ-021 SHALL, in ST_IDLE on '#': match -> ST_OPEN, fail_cnt cleared; no match -> err pulse, fail_cnt+1, ST_LOCK if fail_cnt+1 = MAX_FAIL else stay in ST_IDLE; buffer cleared either way.
REQ-022 SHALL, in ST_IDLE on '*': match -> ST_NEW, fail_cnt cleared; no match -> handled as a failed '#'.
REQ-023 SHALL hold lockOP high for exactly UNLOCK_CYC cycles in ST_OPEN, then return to ST_IDLE; keys in ST_OPEN are ignored.
REQ-024 SHALL, in ST_NEW on '#': length >= MIN_LEN and no overflow -> copy buffer to a candidate register, ST_CONF; otherwise err pulse, ST_IDLE.
REQ-025 SHALL, in ST_CONF on '#': buffer equals candidate (length included) -> commit candidate to password store, pw_chg pulse, ST_IDLE; else err pulse, ST_IDLE, password unchanged.
REQ-026 SHALL, in ST_NEW/ST_CONF on '*': err pulse, ST_IDLE, password unchanged.
REQ-027 SHALL ignore all keys and sw_reset in ST_LOCK; after LOCKOUT_CYC cycles go to ST_IDLE with fail_cnt cleared.
REQ-028 SHALL, on sw_reset high in any state except ST_LOCK, go to ST_NEW next cycle with buffer cleared; sw_reset takes priority over a same-cycle key_v.
REQ-029 SHALL clear the entry buffer on every state transition.
REQ-030 SHALL register all outputs; a state change is visible on outputs one cycle after the deciding key_v edge.
REQ-031 SHALL saturate fail_cnt at MAX_FAIL.

Reset
REQ-032 SHALL on rst: state ST_IDLE, password 1,2,3,4 length 4, buffer/candidate empty, fail_cnt 0, all timers 0, lockOP/storeLED/alarm/err/pw_chg 0.
REQ-033 SHALL let rst abort any operation including ST_OPEN and ST_LOCK immediately.

Verification
REQ-034 SHALL cover: after rst, keys 1,2,3,4,# -> lockOP high for exactly 500 cycles, fail_cnt 0.
REQ-035 SHALL cover: keys 1,2,3,# then 9,9,9,9,# then 1,2,3,4,5,# -> three err pulses, alarm high 1000 cycles, keys ignored, then ST_IDLE, fail_cnt 0.
REQ-036 SHALL cover: 1,2,3,4,* then 5,6,7,8,9,# then 5,6,7,8,9,# -> pw_chg pulse; then 5,6,7,8,9,# unlocks and 1,2,3,4,# fails.
REQ-037 SHALL cover: sw_reset pulse, 7,7,# -> err pulse (below MIN_LEN), password unchanged; sw_reset with same-cycle key_v -> ST_NEW, key dropped.
REQ-038 SHALL cover: nine digits 1..9 then # with MAX_LEN=8 -> overflow, err; and rst asserted mid-ST_OPEN -> lockOP low asynchronously.
